axi4_lite_slave_regfile: RTL

- AXI4-Lite responder terminating one crossbar slave port.
- Holds a bank of NUM_REGS 32-bit memory-mapped registers.
- Independent write path (AW/W/B) and read path (AR/R); byte-strobed writes.
- Out-of-range accesses return SLVERR when AXI4_LITE_REGFILE_SLVERR_EN is defined; otherwise they return OKAY with no effect.
- Register 0 is exported as a control word for local logic.

---
 rtl/axi4_lite_pkg.sv | 26 ++
 rtl/axi4_lite_reg_array.sv | 38 +++
 rtl/axi4_lite_slave_regfile.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths and the
// write/read FSM state encodings used by axi4_lite_slave_regfile.
package axi4_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axi4_lite_reg_array.sv
// NUM_REGS x 32-bit register bank: one byte-strobed synchronous write port,
// one combinational read port, register 0 exported.
module axi4_lite_reg_array
  import axi4_lite_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] reg0_o
);

  localparam logic [IDX_W:0] NREGS = (IDX_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++)
        if (wstrb_i[b]) regs_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  // Guard keeps non-power-of-two banks from indexing past the end.
  assign rdata_o = ({1'b0, raddr_i} < NREGS) ? regs_q[raddr_i] : '0;
  assign reg0_o  = regs_q[0];

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file with independent write/read FSMs.
// Define AXI4_LITE_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] awaddr_in,
  input  logic [2:0]        awprot_in,
  input  logic              awvalid_in,
  output logic              awready_out,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [STRB_W-1:0] wstrb_in,
  input  logic              wvalid_in,
  output logic              wready_out,
  output logic [1:0]        bresp_out,
  output logic              bvalid_out,
  input  logic              bready_in,
  input  logic [ADDR_W-1:0] araddr_in,
  input  logic [2:0]        arprot_in,
  input  logic              arvalid_in,
  output logic              arready_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [1:0]        rresp_out,
  output logic              rvalid_out,
  input  logic              rready_in,
  output logic [DATA_W-1:0] ctrl_reg_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-3:0] NREGS = (ADDR_W - 2)'(NUM_REGS);
`ifdef AXI4_LITE_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic aw_hs, w_hs, ar_hs, commit, w_in_range, r_in_range;
  logic [ADDR_W-1:0] waddr_eff;
  logic [DATA_W-1:0] wdata_eff, arr_rdata;
  logic [STRB_W-1:0] wstrb_eff;

  assign aw_hs = awvalid_in & awready_q;
  assign w_hs  = wvalid_in & wready_q;
  assign ar_hs = arvalid_in & arready_q;

  // A half already latched takes precedence over the live bus value.
  assign waddr_eff = (wstate_q == W_HAVE_A) ? awaddr_q : awaddr_in;
  assign wdata_eff = (wstate_q == W_HAVE_D) ? wdata_q : wdata_in;
  assign wstrb_eff = (wstate_q == W_HAVE_D) ? wstrb_q : wstrb_in;
  assign commit = ((wstate_q == W_IDLE) & aw_hs & w_hs) |
                  ((wstate_q == W_HAVE_A) & w_hs) |
                  ((wstate_q == W_HAVE_D) & aw_hs);
  assign w_in_range = waddr_eff[ADDR_W-1:2] < NREGS;
  assign r_in_range = araddr_in[ADDR_W-1:2] < NREGS;

  axi4_lite_reg_array #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL),
    .IDX_W     (IDX_W)
  ) u_regs (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .we_i    (commit & w_in_range),
    .waddr_i (waddr_eff[IDX_W+1:2]),
    .wdata_i (wdata_eff),
    .wstrb_i (wstrb_eff),
    .raddr_i (araddr_in[IDX_W+1:2]),
    .rdata_o (arr_rdata),
    .reg0_o  (ctrl_reg_out)
  );

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_d = W_RESP;
        else if (aw_hs)    wstate_d = W_HAVE_A;
        else if (w_hs)     wstate_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)      wstate_d = W_RESP;
      W_HAVE_D: if (aw_hs)     wstate_d = W_RESP;
      W_RESP:   if (bready_in) wstate_d = W_IDLE;
      default:                 wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs)     rstate_d = R_DATA;
      R_DATA:  if (rready_in) rstate_d = R_IDLE;
      default:                rstate_d = R_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state and registered, so
  // they stay low throughout reset and rise on the first edge after it.
  always_comb begin
    awready_d = (wstate_d == W_IDLE) | (wstate_d == W_HAVE_D);
    wready_d  = (wstate_d == W_IDLE) | (wstate_d == W_HAVE_A);
    bvalid_d  = (wstate_d == W_RESP);
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (commit) bresp_q <= w_in_range ? RESP_OKAY : RESP_OOR;
      if (ar_hs) begin
        rresp_q <= r_in_range ? RESP_OKAY : RESP_OOR;
        rdata_q <= r_in_range ? arr_rdata : '0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if ((wstate_q == W_IDLE) && aw_hs && !w_hs) awaddr_q <= awaddr_in;
    if ((wstate_q == W_IDLE) && w_hs && !aw_hs) begin
      wdata_q <= wdata_in;
      wstrb_q <= wstrb_in;
    end
  end

  assign awready_out = awready_q;
  assign wready_out  = wready_q;
  assign bvalid_out  = bvalid_q;
  assign bresp_out   = bresp_q;
  assign arready_out = arready_q;
  assign rvalid_out  = rvalid_q;
  assign rresp_out   = rresp_q;
  assign rdata_out   = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{awprot_in, arprot_in};

endmodule
